// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and helpers for the LED matrix scanner.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

  // Bit position of pixel (row, col) in the flat segment map.
  function automatic int seg_bit(input int row, input int col, input int ncols);
    return row * ncols + col;
  endfunction

  // Convert a logical "1 = active" pattern into pin levels.
  // Patterns are limited to 32 pins per side.
  function automatic logic [31:0] apply_pol(input logic [31:0] v, input logic invert);
    return invert ? ~v : v;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// Loadable down-counter used for both the blanking gap and the row dwell.
// done_o is high while the count sits at zero; a load restarts the count.
module scan_timer
  import led_matrix_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed ROWS x COLS LED matrix driver with per-row dwell,
// blanking between rows and a frame-latched pixel buffer.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS            = 3,
  parameter int COLS            = 3,
  parameter int DIV_WIDTH       = 16,
  parameter int DEAD_CYCLES     = 1,
  parameter int ROW_ACTIVE_HIGH = 1,
  parameter int COL_ACTIVE_LOW  = 1,
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [ROWS*COLS-1:0] segments,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic [RIW-1:0]       row_idx,
  output logic                 frame_start
);

  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int TW     = (DIV_WIDTH > DEAD_W) ? DIV_WIDTH : DEAD_W;
  localparam logic [TW-1:0] BLANK_LOAD = TW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [ROWS-1:0] ROWS_OFF = (ROW_ACTIVE_HIGH != 0) ? '0 : '1;
  localparam logic [COLS-1:0] COLS_OFF = (COL_ACTIVE_LOW != 0) ? '1 : '0;

  scan_state_t          state_q;
  logic [RIW-1:0]       row_idx_q;
  logic [RIW-1:0]       row_next;
  logic                 row_last;
  logic [ROWS*COLS-1:0] frame_buf_q;
  logic [ROWS-1:0]      rows_q;
  logic [COLS-1:0]      cols_q;
  logic                 frame_start_q;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 tmr_done;

  // Row-select pin levels with only row idx active.
  function automatic logic [ROWS-1:0] row_pins(input logic [RIW-1:0] idx);
    logic [ROWS-1:0] onehot;
    onehot = ROWS'(1) << idx;
    return ROWS'(apply_pol(32'(onehot), ROW_ACTIVE_HIGH == 0));
  endfunction

  // Column pin levels for row idx taken from a pixel map.
  function automatic logic [COLS-1:0] col_pins(input logic [ROWS*COLS-1:0] fb,
                                               input logic [RIW-1:0] idx);
    logic [COLS-1:0] lit;
    lit = COLS'(fb >> seg_bit(int'(idx), 0, COLS));
    return COLS'(apply_pol(32'(lit), COL_ACTIVE_LOW != 0));
  endfunction

  assign row_last = (row_idx_q == RIW'(ROWS - 1));
  assign row_next = row_last ? '0 : row_idx_q + 1'b1;

  // Timer loads on every edge that enters BLANK or DRIVE; div is sampled
  // only when a drive starts so a change never stretches a row in flight.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = BLANK_LOAD;
    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          tmr_load = 1'b1;
          tmr_val  = (DEAD_CYCLES == 0) ? TW'(div) : BLANK_LOAD;
        end
        S_BLANK: begin
          tmr_load = tmr_done;
          tmr_val  = TW'(div);
        end
        S_DRIVE: begin
          tmr_load = tmr_done;
          tmr_val  = (DEAD_CYCLES == 0) ? TW'(div) : BLANK_LOAD;
        end
        default: begin
          tmr_load = 1'b0;
        end
      endcase
    end
  end

  scan_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Scan FSM with registered pin outputs; the frame buffer is refreshed
  // only at frame boundaries so a frame is never drawn from mixed content.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      row_idx_q     <= '0;
      frame_buf_q   <= '0;
      frame_start_q <= 1'b0;
      rows_q        <= ROWS_OFF;
      cols_q        <= COLS_OFF;
    end else begin
      frame_start_q <= 1'b0;
      if (!enable) begin
        state_q   <= S_IDLE;
        row_idx_q <= '0;
        rows_q    <= ROWS_OFF;
        cols_q    <= COLS_OFF;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            frame_buf_q   <= segments;
            frame_start_q <= 1'b1;
            row_idx_q     <= '0;
            if (DEAD_CYCLES == 0) begin
              state_q <= S_DRIVE;
              rows_q  <= row_pins('0);
              cols_q  <= col_pins(segments, '0);
            end else begin
              state_q <= S_BLANK;
              rows_q  <= ROWS_OFF;
              cols_q  <= COLS_OFF;
            end
          end
          S_BLANK: begin
            if (tmr_done) begin
              state_q <= S_DRIVE;
              rows_q  <= row_pins(row_idx_q);
              cols_q  <= col_pins(frame_buf_q, row_idx_q);
            end
          end
          S_DRIVE: begin
            if (tmr_done) begin
              row_idx_q <= row_next;
              if (row_last) begin
                frame_buf_q   <= segments;
                frame_start_q <= 1'b1;
              end
              if (DEAD_CYCLES == 0) begin
                state_q <= S_DRIVE;
                rows_q  <= row_pins(row_next);
                cols_q  <= col_pins(row_last ? segments : frame_buf_q, row_next);
              end else begin
                state_q <= S_BLANK;
                rows_q  <= ROWS_OFF;
                cols_q  <= COLS_OFF;
              end
            end
          end
          default: begin
            state_q   <= S_IDLE;
            row_idx_q <= '0;
            rows_q    <= ROWS_OFF;
            cols_q    <= COLS_OFF;
          end
        endcase
      end
    end
  end

  assign rows        = rows_q;
  assign cols        = cols_q;
  assign row_idx     = row_idx_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Parametrised time-multiplexed driver for a ROWS x COLS LED matrix; successor to the fixed 3x3 nine-segment-to-six-pin converter.
- Scans one row at a time and drives that row's column pattern.
- Adds a programmable per-row dwell time, anti-ghosting blanking between rows, and a frame-latched input buffer so a frame never tears.
- Configurable output polarities.
- Sits between display-content logic and the FPGA LED pins.

Parameters:
- ROWS, 3: number of matrix rows, ≥1.
- COLS, 3: number of matrix columns, ≥1.
- DIV_WIDTH, 16: width of the dwell divider input.
- DEAD_CYCLES, 1: clocks of full blanking before each row drive, ≥0.
- ROW_ACTIVE_HIGH, 1: 1 = selected row pin driven 1; 0 = driven 0.
- COL_ACTIVE_LOW, 1: 1 = lit column pin driven 0; 0 = driven 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scanning enable; 0 forces display off
- div  in  DIV_WIDTH  row dwell minus one; drive lasts div+1 clocks
- segments  in  ROWS*COLS  pixel map, bit r*COLS+c = row r, col c, 1 = lit
- rows  out  ROWS  row select pins, polarity per ROW_ACTIVE_HIGH
- cols  out  COLS  column pins, polarity per COL_ACTIVE_LOW
- row_idx  out  $clog2(ROWS) (min 1)  row currently in BLANK/DRIVE
- frame_start  out  1  one-clock pulse when a new frame is latched

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All outputs are registered.
- Reset state:
  - State S_IDLE; row_idx=0; frame_start=0; frame buffer cleared.
  - rows all inactive (default 000); cols all inactive (default 111).
  - Reset mid-operation forces these values immediately, without waiting for a clock edge.
- Inactive outputs: rows inactive = ~ROW_ACTIVE_HIGH replicated; cols inactive = COL_ACTIVE_LOW replicated.
- FSM states: S_IDLE, S_BLANK, S_DRIVE.
- S_IDLE:
  - Outputs inactive.
  - When enable=1, next edge: latch segments into frame_buf, pulse frame_start, row_idx=0, go to S_BLANK. If DEAD_CYCLES=0, go directly to S_DRIVE.
- S_BLANK:
  - rows and cols inactive.
  - Stays DEAD_CYCLES clocks, then goes to S_DRIVE.
  - On the edge into S_DRIVE, latch div into dwell_cnt.
- S_DRIVE:
  - rows: only bit row_idx active.
  - cols[c] active iff frame_buf[row_idx*COLS+c]=1.
  - Stays div_latched+1 clocks.
  - At the end: row_idx increments and goes to S_BLANK (or S_DRIVE if DEAD_CYCLES=0).
  - Wrap: after row ROWS-1, row_idx=0, re-latch segments into frame_buf, pulse frame_start on that edge.
- Frame period = ROWS*(DEAD_CYCLES+div+1) clocks when div is constant.
- div changes take effect at the next row's drive start, never mid-drive.
- segments changes are invisible until the next frame_start.
- enable=0 in any state: next edge goes to S_IDLE with outputs inactive and row_idx=0. Re-enable always restarts at row 0 with a fresh latch.
- ROWS=1 is legal: row 0 every slot, frame_start every row.

Decomposition:
- Package led_matrix_pkg:
  - typedef enum logic [1:0] scan_state_t {S_IDLE, S_BLANK, S_DRIVE}.
  - Function for row/col index to segment bit.
  - Function for polarity application.
- Sub-module scan_timer: loadable down-counter (load value, done flag) used for both blank and dwell countdown.

Test Plan:
All scenarios use defaults (3x3, DEAD_CYCLES=1, active-high rows, active-low cols) unless stated.
1. reset=1, then release with enable=0 -> rows=000, cols=111, row_idx=0, frame_start=0 held indefinitely.
2. enable=1, div=0, segments=0 -> rows sequence 000,001,000,010,000,100,000,001..., cols=111 throughout; frame_start every 6 clocks.
3. segments=9'b000010000, div=0 -> row1 drive: rows=010, cols=101; row0 and row2 drive: cols=111; blanks: rows=000, cols=111.
4. div=3, segments=9'b111111111 -> each drive is 4 clocks with cols=000; frame period 15 clocks; frame_start spacing exactly 15.
5. Change segments from 0 to 9'b000000001 while row1 is driving -> cols stay 111 until the next frame_start; then row0 drive shows cols=110.
6. Drop enable mid row1 drive -> next edge rows=000, cols=111. Re-enable restarts at row0. Assert reset asynchronously mid drive -> outputs go inactive before the next clock edge.
